// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of an external waveform
// and derives a per-mille duty with a 10-step restoring divider.
module pwm_capture #(
  parameter int SYS_FREQ    = 125,
  parameter int TIMEOUT_CYC = SYS_FREQ * 1000 * 100
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        enable,
  input  logic        pwm_in,
  output logic [26:0] period_out,
  output logic [26:0] high_out,
  output logic [9:0]  duty,
  output logic        valid,
  output logic        no_signal,
  output logic        overrun
);

  localparam logic [26:0] LP_TIMEOUT = 27'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, DIVIDE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_s1, r_s2, r_s3;
  logic [26:0] r_per, r_hi;
  logic [26:0] r_cap_per, r_cap_hi;
  logic [36:0] r_rem, r_dvs;
  logic [8:0]  r_q;
  logic [3:0]  r_div_cnt;
  logic        r_to_done;
  logic [26:0] r_period, r_high;
  logic [9:0]  r_duty;
  logic        r_valid, r_no_signal, r_overrun;

  logic        w_edge, w_timeout, w_qbit;
  logic [37:0] w_diff;

  assign w_edge    = r_s2 & ~r_s3;
  // An edge in the same cycle always beats the timeout.
  assign w_timeout = enable && (r_state != IDLE) && !w_edge && !r_to_done
                     && (r_per == LP_TIMEOUT);
  assign w_diff    = {1'b0, r_rem} - {1'b0, r_dvs};
  assign w_qbit    = ~w_diff[37];

  // NOTE: asynchronous reset belongs in the sensitivity list, and sequential
  // state is written with <= so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: default assignment first, so no path through this block infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:      w_state_nxt = WAIT_EDGE;
        WAIT_EDGE: if (w_edge) w_state_nxt = MEASURE;
        MEASURE: begin
          if (w_edge)         w_state_nxt = DIVIDE;
          else if (w_timeout) w_state_nxt = WAIT_EDGE;
        end
        DIVIDE: begin
          if (w_timeout)             w_state_nxt = WAIT_EDGE;
          else if (r_div_cnt == '0)  w_state_nxt = MEASURE;
        end
        default:   w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_per       <= '0;
      r_hi        <= '0;
      r_cap_per   <= '0;
      r_cap_hi    <= '0;
      r_rem       <= '0;
      r_dvs       <= '0;
      r_q         <= '0;
      r_div_cnt   <= '0;
      r_to_done   <= 1'b0;
      r_period    <= '0;
      r_high      <= '0;
      r_duty      <= '0;
      r_valid     <= 1'b0;
      r_no_signal <= 1'b1;
      r_overrun   <= 1'b0;
    end else begin
      r_s1    <= pwm_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;

      if (!enable || r_state == IDLE) begin
        r_per     <= '0;
        r_hi      <= '0;
        r_overrun <= 1'b0;
        r_to_done <= 1'b0;
        r_div_cnt <= '0;
      end else if (w_timeout) begin
        r_period    <= '0;
        r_high      <= '0;
        r_duty      <= r_s2 ? 10'd1000 : 10'd0;
        r_no_signal <= 1'b1;
        r_valid     <= 1'b1;
        r_per       <= '0;
        r_hi        <= '0;
        r_to_done   <= 1'b1;
        r_div_cnt   <= '0;
      end else begin
        if (w_edge) begin
          r_per     <= 27'd1;
          r_hi      <= 27'd1;
          r_to_done <= 1'b0;
          if (r_state == MEASURE) begin
            r_cap_per <= r_per;
            r_cap_hi  <= r_hi;
            r_rem     <= 37'(r_hi) * 37'd1000;
            r_dvs     <= {1'b0, r_per, 9'd0};
            r_q       <= '0;
            r_div_cnt <= 4'd10;
          end else if (r_state == DIVIDE) begin
            r_overrun <= 1'b1;
          end
        end else begin
          // After a timeout the counter parks at zero until the next edge.
          if (!r_to_done)                   r_per <= r_per + 27'd1;
          if (r_state != WAIT_EDGE && r_s2) r_hi  <= r_hi + 27'd1;
        end

        if (r_state == DIVIDE && r_div_cnt != '0) begin
          r_div_cnt <= r_div_cnt - 4'd1;
          if (w_qbit) r_rem <= w_diff[36:0];
          r_dvs <= r_dvs >> 1;
          r_q   <= {r_q[7:0], w_qbit};
          if (r_div_cnt == 4'd1) begin
            r_period    <= r_cap_per;
            r_high      <= r_cap_hi;
            r_duty      <= {r_q, w_qbit};
            r_no_signal <= 1'b0;
            r_valid     <= 1'b1;
          end
        end
      end
    end
  end

  assign period_out = r_period;
  assign high_out   = r_high;
  assign duty       = r_duty;
  assign valid      = r_valid;
  assign no_signal  = r_no_signal;
  assign overrun    = r_overrun;

endmodule
